// File: rtl/packet_filter_pkg.sv
// Shared types for the store-and-forward packet filter: write FSM states,
// the buffer word layout and a saturating counter helper.
package packet_filter_pkg;

  localparam int unsigned PF_DWIDTH = 64;
  localparam int unsigned PF_EWIDTH = $clog2(PF_DWIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [PF_DWIDTH-1:0] data;
    logic                 sop;
    logic                 eop;
    logic [PF_EWIDTH-1:0] empty;
  } buf_word_t;

  function automatic logic [31:0] sat_add(input logic [31:0] value, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, value} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle with sink/src views; channel qualifies the eop beat.
interface avalon_st_if #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = $clog2(DWIDTH / 8)
);
  logic [DWIDTH-1:0]        data;
  logic                     valid;
  logic                     ready;
  logic                     sop;
  logic                     eop;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport sink (input data, valid, sop, eop, empty, channel, output ready);
  modport src  (output data, valid, sop, eop, empty, channel, input ready);
endinterface

// File: rtl/filter_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
module filter_buf_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage arrays are never reset; validity is tracked by the pointers
  // outside, and leaving them reset-free lets them map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/packet_filter.sv
// Store-and-forward filter: buffers each packet, forwards it only when the
// channel on its eop beat is nonzero, drops it otherwise or on overflow.
module packet_filter
  import packet_filter_pkg::*;
#(
  parameter  int AST_DWIDTH    = 64,
  parameter  int CHANNEL_WIDTH = 1,
  parameter  int BUF_DEPTH     = 256,
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8)
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  avalon_st_if.sink   ast_sink_if,
  avalon_st_if.src    ast_src_if,
  output logic [31:0] pkt_pass_cnt_o,
  output logic [31:0] pkt_drop_cnt_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $bits(buf_word_t);

  wr_state_e state, nxt_state;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] nxt_wr_ptr, nxt_commit_ptr, fill;
  logic          full, sink_rdy, beat_acc, chan_hit, start_pkt;
  logic          wr_en, chan_wr, pass_inc;
  logic [1:0]    drop_inc;
  logic [AW-1:0] wr_addr;
  buf_word_t     wr_word, rd_word, out_word;

  logic                     rd_en, load_out, s1_vld, out_vld;
  logic [CHANNEL_WIDTH-1:0] s1_chan, out_chan;
  logic [CHANNEL_WIDTH-1:0] chan_mem [BUF_DEPTH];

  assign ast_sink_if.ready = sink_rdy;
  assign beat_acc = ast_sink_if.valid && sink_rdy;
  assign chan_hit = |ast_sink_if.channel;
  // Modulo subtraction on the extra-MSB pointers gives occupancy incl. full.
  assign fill     = wr_ptr - rd_ptr;
  assign full     = (fill == PW'(BUF_DEPTH));

  assign wr_word.data  = PF_DWIDTH'(ast_sink_if.data);
  assign wr_word.sop   = ast_sink_if.sop;
  assign wr_word.eop   = ast_sink_if.eop;
  assign wr_word.empty = PF_EWIDTH'(ast_sink_if.empty);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nxt_state      = state;
    nxt_wr_ptr     = wr_ptr;
    nxt_commit_ptr = commit_ptr;
    wr_en          = 1'b0;
    wr_addr        = wr_ptr[AW-1:0];
    chan_wr        = 1'b0;
    pass_inc       = 1'b0;
    drop_inc       = 2'd0;
    start_pkt      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (beat_acc && ast_sink_if.sop) begin
          if (full) begin
            drop_inc  = 2'd1;
            nxt_state = ast_sink_if.eop ? ST_IDLE : ST_DROP;
          end else begin
            start_pkt = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (beat_acc) begin
          if (ast_sink_if.sop) begin
            // Abort the unterminated packet; the new beat restarts at commit_ptr.
            drop_inc  = 2'd1;
            start_pkt = 1'b1;
          end else if (full) begin
            nxt_wr_ptr = commit_ptr;
            drop_inc   = 2'd1;
            nxt_state  = ast_sink_if.eop ? ST_IDLE : ST_DROP;
          end else begin
            wr_en      = 1'b1;
            nxt_wr_ptr = wr_ptr + PW'(1);
            if (ast_sink_if.eop) begin
              nxt_state = ST_IDLE;
              if (chan_hit) begin
                nxt_commit_ptr = wr_ptr + PW'(1);
                pass_inc       = 1'b1;
                chan_wr        = 1'b1;
              end else begin
                nxt_wr_ptr = commit_ptr;
                drop_inc   = 2'd1;
              end
            end
          end
        end
      end
      ST_DROP: begin
        if (beat_acc && ast_sink_if.eop) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase

    if (start_pkt) begin
      wr_en      = 1'b1;
      wr_addr    = commit_ptr[AW-1:0];
      nxt_wr_ptr = commit_ptr + PW'(1);
      nxt_state  = ST_RECV;
      if (ast_sink_if.eop) begin
        nxt_state = ST_IDLE;
        if (chan_hit) begin
          nxt_commit_ptr = commit_ptr + PW'(1);
          pass_inc       = 1'b1;
          chan_wr        = 1'b1;
        end else begin
          nxt_wr_ptr = commit_ptr;
          drop_inc   = drop_inc + 2'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      sink_rdy       <= 1'b0;
      pkt_pass_cnt_o <= '0;
      pkt_drop_cnt_o <= '0;
    end else begin
      state          <= nxt_state;
      wr_ptr         <= nxt_wr_ptr;
      commit_ptr     <= nxt_commit_ptr;
      sink_rdy       <= 1'b1;
      pkt_pass_cnt_o <= sat_add(pkt_pass_cnt_o, {1'b0, pass_inc});
      pkt_drop_cnt_o <= sat_add(pkt_drop_cnt_o, drop_inc);
    end
  end

  // Channel is kept at the packet's start address, valid until that slot is reread.
  always_ff @(posedge clk_i) begin
    if (chan_wr) chan_mem[commit_ptr[AW-1:0]] <= ast_sink_if.channel;
  end

  filter_buf_ram #(.WIDTH(WW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  // Two-stage read: RAM output register (s1) feeding the src output register.
  assign load_out = s1_vld && (!out_vld || ast_src_if.ready);
  assign rd_en    = (rd_ptr != commit_ptr) && (!s1_vld || load_out);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rd_ptr   <= '0;
      s1_vld   <= 1'b0;
      s1_chan  <= '0;
      out_vld  <= 1'b0;
      out_word <= '0;
      out_chan <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr  <= rd_ptr + PW'(1);
        s1_chan <= chan_mem[rd_ptr[AW-1:0]];
        s1_vld  <= 1'b1;
      end else if (load_out) begin
        s1_vld <= 1'b0;
      end
      if (load_out) begin
        out_vld  <= 1'b1;
        out_word <= rd_word;
        if (rd_word.sop) out_chan <= s1_chan;
      end else if (ast_src_if.ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign ast_src_if.valid   = out_vld;
  assign ast_src_if.data    = out_word.data[AST_DWIDTH-1:0];
  assign ast_src_if.sop     = out_word.sop;
  assign ast_src_if.eop     = out_word.eop;
  assign ast_src_if.empty   = out_word.empty[EMPTY_WIDTH-1:0];
  assign ast_src_if.channel = out_chan;
endmodule

// File: tb/tb_packet_filter.sv
// Bench for packet_filter: packet-level scoreboard model plus directed scenarios.
module tb_packet_filter;
  localparam int DEPTH = 4;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b1;
  always #5 clk_i = ~clk_i;

  avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1)) sink_if ();
  avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1)) src_if ();
  logic [31:0] pass_cnt, drop_cnt;

  packet_filter #(.AST_DWIDTH(64), .CHANNEL_WIDTH(1), .BUF_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .ast_sink_if    (sink_if),
    .ast_src_if     (src_if),
    .pkt_pass_cnt_o (pass_cnt),
    .pkt_drop_cnt_o (drop_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        ch;
  } word_t;

  word_t exp_q[$];
  word_t cur_q[$];
  int    m_pass, m_drop;
  bit    in_pkt, dropping;
  int    n_checks, n_errors;
  int    cyc, last_xfer, max_gap;
  bit    held;
  logic [63:0] h_data;
  logic [5:0]  h_ctrl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a packet is forwarded whole iff it ends with a nonzero
  // channel and never exceeded DEPTH words; an early sop aborts the old one.
  function automatic void model_beat();
    word_t w;
    w.data  = sink_if.data;
    w.sop   = sink_if.sop;
    w.eop   = sink_if.eop;
    w.empty = sink_if.empty;
    w.ch    = 1'b0;
    if (dropping) begin
      if (w.eop) dropping = 1'b0;
      return;
    end
    if (!in_pkt) begin
      if (!w.sop) return;
      in_pkt = 1'b1;
      cur_q.delete();
    end else if (w.sop) begin
      m_drop++;
      cur_q.delete();
    end
    if (cur_q.size() == DEPTH) begin
      m_drop++;
      in_pkt   = 1'b0;
      dropping = !w.eop;
      cur_q.delete();
      return;
    end
    cur_q.push_back(w);
    if (w.eop) begin
      in_pkt = 1'b0;
      if (sink_if.channel != 0) begin
        foreach (cur_q[i]) begin
          word_t t;
          t    = cur_q[i];
          t.ch = sink_if.channel;
          exp_q.push_back(t);
        end
        m_pass++;
      end else begin
        m_drop++;
      end
      cur_q.delete();
    end
  endfunction

  always @(posedge clk_i)
    if (arstn_i && sink_if.valid && sink_if.ready) model_beat();

  always @(negedge arstn_i) begin
    exp_q.delete();
    cur_q.delete();
    m_pass   = 0;
    m_drop   = 0;
    in_pkt   = 1'b0;
    dropping = 1'b0;
    held     = 1'b0;
  end

  always @(negedge clk_i) begin
    if (arstn_i) begin
      word_t e;
      cyc++;
      if (src_if.valid) begin
        if (held) begin
          check("stall_data", src_if.data, h_data);
          check("stall_ctrl", {src_if.sop, src_if.eop, src_if.empty, src_if.channel}, h_ctrl);
        end
        if (src_if.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word_valid", src_if.valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", src_if.data, e.data);
            check("out_ctrl", {src_if.sop, src_if.eop, src_if.empty, src_if.channel},
                  {e.sop, e.eop, e.empty, e.ch});
          end
          if (last_xfer >= 0 && cyc - last_xfer > max_gap) max_gap = cyc - last_xfer;
          last_xfer = cyc;
        end
      end
      check("pass_cnt", pass_cnt, 64'(m_pass));
      check("drop_cnt", drop_cnt, 64'(m_drop));
      held   = src_if.valid && !src_if.ready;
      h_data = src_if.data;
      h_ctrl = {src_if.sop, src_if.eop, src_if.empty, src_if.channel};
    end
  end

  task automatic send_beat(input logic [63:0] d, input bit s, input bit e,
                           input logic [2:0] emp, input bit ch);
    sink_if.valid   = 1'b1;
    sink_if.data    = d;
    sink_if.sop     = s;
    sink_if.eop     = e;
    sink_if.empty   = emp;
    sink_if.channel = ch;
    @(posedge clk_i);
    #1;
    sink_if.valid = 1'b0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
  endtask

  // Non-eop beats carry the inverted channel so only the eop beat may matter.
  task automatic send_pkt(input int id, input int n, input bit ch, input logic [2:0] emp);
    for (int i = 0; i < n; i++)
      send_beat({16'hA5A5, 16'(id), 32'(i)}, i == 0, i == n - 1,
                (i == n - 1) ? emp : 3'd0, (i == n - 1) ? ch : ~ch);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
    check(name, 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_xfer = -1; max_gap = 0;
    sink_if.valid = 1'b0; sink_if.sop = 1'b0; sink_if.eop = 1'b0;
    sink_if.data = '0; sink_if.empty = '0; sink_if.channel = '0;
    src_if.ready = 1'b1;

    // Reset state
    #2 arstn_i = 1'b0;
    #20;
    check("rst_valid", src_if.valid, 1'b0);
    check("rst_sink_ready", sink_if.ready, 1'b0);
    check("rst_pass", pass_cnt, 64'd0);
    check("rst_drop", drop_cnt, 64'd0);
    check("rst_data", src_if.data, 64'd0);
    check("rst_sop_eop", {src_if.sop, src_if.eop}, 2'b00);
    #11 arstn_i = 1'b1;
    idle(3);

    // 3-word matching packet; first word 2 cycles after eop acceptance
    send_pkt(1, 3, 1'b1, 3'd5);
    @(negedge clk_i); check("lat_valid_c0", src_if.valid, 1'b0);
    @(negedge clk_i); check("lat_valid_c1", src_if.valid, 1'b0);
    @(negedge clk_i); check("lat_valid_c2", src_if.valid, 1'b1);
    check("lat_first_data", src_if.data, 64'hA5A5_0001_0000_0000);
    check("lat_first_sop", src_if.sop, 1'b1);
    wait_drain("drain_p1");
    check("p1_pass", pass_cnt, 64'd1);

    // Non-matching packet dropped, next matching one intact
    send_pkt(2, 3, 1'b0, 3'd0);
    idle(6);
    check("p2_drop", drop_cnt, 64'd1);
    send_pkt(3, 2, 1'b1, 3'd2);
    wait_drain("drain_p3");
    check("p3_pass", pass_cnt, 64'd2);

    // Oversize packet (6 > DEPTH) dropped, following packet passes
    send_pkt(4, 6, 1'b1, 3'd0);
    idle(6);
    check("p4_drop", drop_cnt, 64'd2);
    send_pkt(5, 2, 1'b1, 3'd7);
    wait_drain("drain_p5");
    check("p5_pass", pass_cnt, 64'd3);

    // Output stall with a second packet queued behind the first
    src_if.ready = 1'b0;
    send_pkt(6, 3, 1'b1, 3'd1);
    idle(3);
    send_pkt(7, 3, 1'b1, 3'd4);
    idle(8);
    check("stall_valid", src_if.valid, 1'b1);
    check("stall_first_data", src_if.data, 64'hA5A5_0006_0000_0000);
    last_xfer = -1; max_gap = 0;
    src_if.ready = 1'b1;
    wait_drain("drain_p6_p7");
    check("b2b_max_gap", 64'(max_gap), 64'd1);
    check("p7_pass", pass_cnt, 64'd5);

    // Unterminated packet aborted by a 1-word sop+eop packet
    send_beat({16'hA5A5, 16'd8, 32'd0}, 1'b1, 1'b0, 3'd0, 1'b0);
    send_beat({16'hA5A5, 16'd8, 32'd1}, 1'b0, 1'b0, 3'd0, 1'b1);
    send_beat({16'hA5A5, 16'd9, 32'd0}, 1'b1, 1'b1, 3'd3, 1'b1);
    wait_drain("drain_p9");
    check("p9_drop", drop_cnt, 64'd3);
    check("p9_pass", pass_cnt, 64'd6);

    // Asynchronous reset mid-packet
    send_beat({16'hA5A5, 16'd10, 32'd0}, 1'b1, 1'b0, 3'd0, 1'b0);
    send_beat({16'hA5A5, 16'd10, 32'd1}, 1'b0, 1'b0, 3'd0, 1'b0);
    #2 arstn_i = 1'b0;
    #1;
    check("arst_valid", src_if.valid, 1'b0);
    check("arst_data", src_if.data, 64'd0);
    check("arst_sink_ready", sink_if.ready, 1'b0);
    check("arst_pass", pass_cnt, 64'd0);
    check("arst_drop", drop_cnt, 64'd0);
    #14 arstn_i = 1'b1;
    idle(2);
    send_pkt(11, 2, 1'b1, 3'd6);
    wait_drain("drain_p11");
    check("p11_pass", pass_cnt, 64'd1);
    check("p11_drop", drop_cnt, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/packet_filter.md
PACKET_FILTER -- requirements
Module: packet_filter

Interface
REQ-001 SHALL have parameter AST_DWIDTH, default 64, Avalon-ST data width in bits.
REQ-002 SHALL have parameter CHANNEL_WIDTH, default 1, Avalon-ST channel width.
REQ-003 SHALL have parameter BUF_DEPTH, default 256, buffer depth in words; power of two, at least 4.
REQ-004 SHALL have derived constant EMPTY_WIDTH = $clog2(AST_DWIDTH/8).
REQ-005 SHALL have port clk_i, input, 1 bit, single clock; all logic on the rising edge.
REQ-006 SHALL have port arstn_i, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port ast_sink_if, avalon_st_if.sink, classified stream from the upstream classer; channel is valid on the eop beat.
REQ-008 SHALL have port ast_src_if, avalon_st_if.src, filtered output stream.
REQ-009 SHALL have port pkt_pass_cnt_o, output, 32 bits, count of forwarded packets.
REQ-010 SHALL have port pkt_drop_cnt_o, output, 32 bits, count of discarded packets.

Function
REQ-011 SHALL operate store-and-forward: a packet is emitted only after its sink eop beat is accepted, and only if the sink channel on that beat is nonzero.
REQ-012 SHALL hold sink ready at 1 outside reset; no input backpressure; overflow is handled by dropping.
REQ-013 SHALL accept a sink beat only when valid=1 and ready=1.
REQ-014 SHALL store data, sop, eop and empty of each accepted beat in one buffer word.
REQ-015 SHALL keep pointers of $clog2(BUF_DEPTH)+1 bits: wr_ptr, commit_ptr (start of the current packet) and rd_ptr.
- full = (wr_ptr - rd_ptr) == BUF_DEPTH; modulo wrap is intended.
REQ-016 SHALL implement the write FSM with states IDLE, RECV and DROP.
REQ-017 In IDLE, a sop beat SHALL be written and the FSM SHALL go to RECV; non-sop beats SHALL be ignored without counting.
REQ-018 A beat with both sop and eop in IDLE SHALL be written and resolved in the same cycle (commit or drop); the FSM stays in IDLE.
REQ-019 In RECV, each beat SHALL be written; on the eop beat:
- channel != 0: commit_ptr <= wr_ptr+1 and pass count +1.
- channel == 0: wr_ptr <= commit_ptr and drop count +1.
- In both cases the FSM goes to IDLE.
REQ-020 In RECV, a beat arriving while full SHALL not be written; wr_ptr <= commit_ptr, drop count +1, FSM goes to DROP (or to IDLE if that beat carries eop).
REQ-021 In RECV, a new sop beat without a prior eop SHALL abort the current packet (wr_ptr rewinds to commit_ptr, drop count +1), and the new beat SHALL be written as a fresh packet start.
REQ-022 In DROP, beats SHALL be discarded until the eop beat, then the FSM goes to IDLE; no further count.
REQ-023 A packet longer than BUF_DEPTH SHALL always be dropped, with the buffer left consistent.
REQ-024 The read side SHALL emit only words in [rd_ptr, commit_ptr), never uncommitted words.
REQ-025 The source SHALL use a buffer with 1-cycle read latency plus an output register.
- src valid stays high until ready=1; data/sop/eop/empty/channel are stable while valid=1 and ready=0.
REQ-026 With src ready held at 1, back-to-back committed words SHALL stream at one word per cycle.
REQ-027 The first word of a committed packet SHALL appear on src 2 cycles after its eop beat is accepted, if the read side is idle.
REQ-028 src channel SHALL be the stored eop-beat channel of the packet being emitted (registered per packet at commit).
REQ-029 Simultaneous commit and read SHALL both take effect; full is evaluated with pre-update rd_ptr (conservative).
REQ-030 Counters SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-031 While arstn_i=0, the following SHALL be held:
- FSM = IDLE; all pointers = 0.
- src valid/sop/eop = 0; src data/empty/channel = 0.
- Both counters = 0; sink ready = 0.
REQ-032 Reset mid-packet SHALL discard all buffered and partial packets; the first accepted sop after reset starts clean.

Structure
REQ-033 Shared package packet_filter_pkg SHALL hold the FSM state enum and the buffer-word struct (data, sop, eop, empty).
REQ-034 Sub-module filter_buf_ram SHALL be a simple dual-port RAM (one write port, one registered read port) of BUF_DEPTH x struct width, with no reset on its contents.

Verification
REQ-035 3-word packet, channel=1 on eop, src ready=1 -> same 3 words out, sop on word 0, eop and empty on word 2; first word 2 cycles after eop; pass=1.
REQ-036 3-word packet, channel=0 on eop -> no src valid; drop=1; next matching packet is emitted intact.
REQ-037 BUF_DEPTH=4, 6-word matching packet -> nothing emitted; drop=1; a following 2-word matching packet is emitted.
REQ-038 Packet A matching; src ready=0 for 10 cycles, then 1 -> A emitted with data held stable during the stall; a second matching packet B arriving during the stall follows immediately after A.
REQ-039 sop, 2 words, then new sop with no eop, then a 1-word sop+eop matching packet -> only the 1-word packet is emitted; drop=1, pass=1.
REQ-040 arstn_i pulsed low mid-packet (asynchronously, between clock edges) -> outputs zero immediately; a later matching packet passes; counters restart from 0.
